// File: rtl/cv32e40p_x_wb_arbiter.sv
// Purpose: shares register-file write port A between the WB stage and x-interface results, buffering results in a FIFO.
// Latency: 0 cycles for a bypassed result (FIFO empty, port free), >= 1 cycle once a result is buffered.
// Backpressure: x_result_ready_o = (count < DEPTH); the WB stage holds when core_wb_stall_o = 1.
//
// Optional feature macro: COREVXIF_WB_STARVE_EN. When defined, a starve counter forces the FIFO head
// onto the port after STARVE_LIMIT consecutive lost cycles. When undefined, the core always wins.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   core_we_i/core_waddr_i/core_wdata_i  WB stage write request
//   x_result_*                           coprocessor result channel (valid/ready)
//   rf_we_o/rf_waddr_o/rf_wdata_o        register-file write port A
//   x_rvalid_o/x_rwaddr_o                scoreboard clear towards the dispatcher
//   core_wb_stall_o                      WB write deferred this cycle
//   x_pending_o                          result FIFO non-empty
module cv32e40p_x_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_we_i,
    input  logic [4:0]  core_waddr_i,
    input  logic [31:0] core_wdata_i,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [4:0]  x_result_rd_i,
    input  logic [31:0] x_result_data_i,
    input  logic        x_result_we_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        x_rvalid_o,
    output logic [4:0]  x_rwaddr_o,
    output logic        core_wb_stall_o,
    output logic        x_pending_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    res_t          fifo_mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic empty;
    logic accept;
    logic x_ok;
    logic pop;
    logic bypass;
    logic push;
    logic x_grant;
    logic force_grant;
    res_t head;

    assign empty            = (count == '0);
    assign x_result_ready_o = (count < CW'(DEPTH));
    assign x_pending_o      = ~empty;
    assign head             = fifo_mem[rptr];

    // x side may take the port when the core is idle or starvation forces it.
    assign accept  = x_result_valid_i & x_result_ready_o;
    assign x_ok    = ~core_we_i | force_grant;
    assign pop     = ~empty & x_ok;
    // Bypass only with an empty FIFO so results never overtake buffered ones.
    assign bypass  = empty & accept & x_result_we_i & x_ok;
    assign push    = accept & x_result_we_i & ~bypass;
    assign x_grant = pop | bypass;

`ifdef COREVXIF_WB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign force_grant     = (starve_cnt == SW'(STARVE_LIMIT));
    assign core_wb_stall_o = core_we_i & x_grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (x_grant) begin
            starve_cnt <= '0;
        end else if (~empty && core_we_i && !force_grant) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign force_grant     = 1'b0;
    assign core_wb_stall_o = 1'b0;
`endif

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        x_rvalid_o = 1'b0;
        x_rwaddr_o = '0;
        if (pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head.rd;
            rf_wdata_o = head.data;
            x_rvalid_o = 1'b1;
            x_rwaddr_o = head.rd;
        end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = x_result_rd_i;
            rf_wdata_o = x_result_data_i;
            x_rvalid_o = 1'b1;
            x_rwaddr_o = x_result_rd_i;
        end else if (core_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wptr] <= '{rd: x_result_rd_i, data: x_result_data_i};
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_wb_arbiter.sv
module tb_cv32e40p_x_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SL    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        xv;
    logic        x_ready;
    logic [4:0]  xrd;
    logic [31:0] xdata;
    logic        xwe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        x_rvalid;
    logic [4:0]  x_rwaddr;
    logic        stall;
    logic        pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40p_x_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .core_we_i        (core_we),
        .core_waddr_i     (core_waddr),
        .core_wdata_i     (core_wdata),
        .x_result_valid_i (xv),
        .x_result_ready_o (x_ready),
        .x_result_rd_i    (xrd),
        .x_result_data_i  (xdata),
        .x_result_we_i    (xwe),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .rf_wdata_o       (rf_wdata),
        .x_rvalid_o       (x_rvalid),
        .x_rwaddr_o       (x_rwaddr),
        .core_wb_stall_o  (stall),
        .x_pending_o      (pending)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered results and a count of lost cycles.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    int   lost = 0;

    always @(negedge clk) begin : cmp
        bit          may_x, from_head, from_in, hs, e_we, e_xv, e_st, nonempty;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        bit          frc;
        if (!rst_n) begin
            q.delete();
            lost = 0;
        end
        frc = 1'b0;
`ifdef COREVXIF_WB_STARVE_EN
        frc = (lost == SL);
`endif
        nonempty  = (q.size() != 0);
        hs        = xv && (q.size() < DEPTH);
        may_x     = !core_we || frc;
        from_head = nonempty && may_x;
        from_in   = !nonempty && hs && xwe && may_x;
        e_we = 1'b0; e_xv = 1'b0; e_a = '0; e_d = '0;
        if (from_head) begin
            e_we = 1'b1; e_xv = 1'b1; e_a = q[0].rd; e_d = q[0].d;
        end else if (from_in) begin
            e_we = 1'b1; e_xv = 1'b1; e_a = xrd; e_d = xdata;
        end else if (core_we) begin
            e_we = 1'b1; e_a = core_waddr; e_d = core_wdata;
        end
        e_st = 1'b0;
`ifdef COREVXIF_WB_STARVE_EN
        e_st = core_we && e_xv;
`endif
        chk("m_ready", x_ready, 32'(q.size() < DEPTH));
        chk("m_pending", pending, 32'(nonempty));
        chk("m_rf_we", rf_we, 32'(e_we));
        if (e_we) begin
            chk("m_rf_waddr", rf_waddr, 32'(e_a));
            chk("m_rf_wdata", rf_wdata, e_d);
        end
        chk("m_x_rvalid", x_rvalid, 32'(e_xv));
        if (e_xv) chk("m_x_rwaddr", x_rwaddr, 32'(e_a));
        chk("m_stall", stall, 32'(e_st));
        if (rst_n) begin
            if (from_head) void'(q.pop_front());
            if (hs && xwe && !from_in) q.push_back('{rd: xrd, d: xdata});
            if (from_head || from_in) lost = 0;
            else if (nonempty && core_we && lost < SL) lost++;
        end
    end

    task automatic drv(input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                       input logic v, input logic [4:0] rd, input logic [31:0] d, input logic we);
        @(posedge clk);
        #2;
        core_we = cw; core_waddr = ca; core_wdata = cd;
        xv = v; xrd = rd; xdata = d; xwe = we;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, limit 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        core_we = 0; core_waddr = 0; core_wdata = 0;
        xv = 0; xrd = 0; xdata = 0; xwe = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        // Reset state
        chk("rst_ready", x_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_x_rvalid", x_rvalid, 0);
        chk("rst_stall", stall, 0);

        // Bypass on an idle port
        drv(0, 0, 0, 1, 5, 32'hDEADBEEF, 1);
        chk("byp_rf_we", rf_we, 1);
        chk("byp_waddr", rf_waddr, 5);
        chk("byp_wdata", rf_wdata, 32'hDEADBEEF);
        chk("byp_rvalid", x_rvalid, 1);
        chk("byp_rwaddr", x_rwaddr, 5);
        chk("byp_pending", pending, 0);

        // Core wins, result buffered, drained next cycle
        drv(1, 3, 32'h33, 1, 7, 32'h77, 1);
        chk("cw_waddr", rf_waddr, 3);
        chk("cw_wdata", rf_wdata, 32'h33);
        chk("cw_rvalid", x_rvalid, 0);
        chk("cw_stall", stall, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("drain_we", rf_we, 1);
        chk("drain_waddr", rf_waddr, 7);
        chk("drain_wdata", rf_wdata, 32'h77);
        chk("drain_rvalid", x_rvalid, 1);
        chk("drain_pending", pending, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("drain_empty", pending, 0);

        // Fill to DEPTH with the core busy, then drain in order
        drv(1, 1, 32'h11, 1, 10, 32'hA0, 1);
        chk("fill0_ready", x_ready, 1);
        drv(1, 1, 32'h11, 1, 11, 32'hA1, 1);
        chk("fill1_ready", x_ready, 1);
        drv(1, 1, 32'h11, 1, 12, 32'hA2, 1);
        chk("full_ready", x_ready, 0);
        chk("full_waddr", rf_waddr, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("full_pop_waddr", rf_waddr, 10);
        chk("full_pop_wdata", rf_wdata, 32'hA0);
        chk("full_pop_ready", x_ready, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("pop2_waddr", rf_waddr, 11);
        chk("pop2_ready", x_ready, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("pop_done_we", rf_we, 0);
        chk("pop_done_pending", pending, 0);

        // Result without a register write is dropped
        drv(0, 0, 0, 1, 9, 32'h99, 0);
        chk("nowe_ready", x_ready, 1);
        chk("nowe_rf_we", rf_we, 0);
        chk("nowe_rvalid", x_rvalid, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("nowe_pending", pending, 0);

        // Starvation behaviour with the core held busy
        drv(1, 2, 32'h22, 1, 20, 32'hC0, 1);
        chk("stv0_waddr", rf_waddr, 2);
        for (int i = 1; i <= 4; i++) begin
            drv(1, 2, 32'h22, 0, 0, 0, 0);
            chk("stv_core_waddr", rf_waddr, 2);
            chk("stv_core_rvalid", x_rvalid, 0);
            chk("stv_core_stall", stall, 0);
        end
        drv(1, 2, 32'h22, 0, 0, 0, 0);
`ifdef COREVXIF_WB_STARVE_EN
        chk("stv5_rvalid", x_rvalid, 1);
        chk("stv5_waddr", rf_waddr, 20);
        chk("stv5_stall", stall, 1);
        drv(1, 2, 32'h22, 0, 0, 0, 0);
        chk("stv6_waddr", rf_waddr, 2);
        chk("stv6_stall", stall, 0);
        chk("stv6_pending", pending, 0);
`else
        chk("nostv5_rvalid", x_rvalid, 0);
        chk("nostv5_stall", stall, 0);
        chk("nostv5_pending", pending, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("nostv_drain_waddr", rf_waddr, 20);
        chk("nostv_drain_rvalid", x_rvalid, 1);
`endif
        drv(0, 0, 0, 0, 0, 0, 0);

        // Reset with two buffered entries
        drv(1, 4, 32'h44, 1, 21, 32'hB1, 1);
        drv(1, 4, 32'h44, 1, 22, 32'hB2, 1);
        drv(1, 4, 32'h44, 0, 0, 0, 0);
        chk("prerst_pending", pending, 1);
        chk("prerst_ready", x_ready, 0);
        core_we = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_pending", pending, 0);
        chk("midrst_ready", x_ready, 1);
        chk("midrst_rf_we", rf_we, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("postrst_rf_we", rf_we, 0);
        chk("postrst_rvalid", x_rvalid, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("postrst2_rf_we", rf_we, 0);
        chk("postrst2_pending", pending, 0);

        @(posedge clk);
        #7;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
